// File: rtl/dac_pattern_play.sv
// Waveform playback buffer: loads sample words into a block RAM over a slave stream,
// then replays them one-shot or looped on the 128-bit DAC-side master stream.
module dac_pattern_play #(
    parameter int DWIDTH    = 128,
    parameter int ADDR_BITS = 10
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [DWIDTH-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [ADDR_BITS-1:0] play_len,
    input  logic                 loop_en,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          wrap_count,
    output logic [DWIDTH-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0]  len_q, len_d;
    logic                  loop_q, loop_d;
    logic                  issue_done_q, issue_done_d;
    logic [15:0]           wrap_q, wrap_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [DWIDTH-1:0]     rd_data_q;
    logic                  skid_v0_q, skid_v0_d, skid_v1_q, skid_v1_d;
    logic                  skid_l0_q, skid_l0_d, skid_l1_q, skid_l1_d;
    logic [DWIDTH-1:0]     skid_d0_q, skid_d0_d, skid_d1_q, skid_d1_d;

    logic [DWIDTH-1:0]     mem_q [0:(1<<ADDR_BITS)-1];

    logic                  wr_en, rd_en, start_go, pop, last_accept, rd_at_end, loop_eff;
    logic [ADDR_BITS-1:0]  rd_addr, len_eff;
    logic [1:0]            credit_cnt;

    assign wr_en       = s_axis_tvalid && (state_q == IDLE);
    assign start_go    = (state_q == IDLE) && start && !stop;
    assign pop         = skid_v0_q && m_axis_tready;
    assign last_accept = pop && skid_l0_q && (state_q == PLAY) && !stop;
    assign len_eff     = start_go ? play_len : len_q;
    assign loop_eff    = start_go ? loop_en : loop_q;
    assign credit_cnt  = {1'b0, skid_v0_q} + {1'b0, skid_v1_q} + {1'b0, rd_valid_q};
    // Skid entries plus the read in flight never exceed two, so a full skid never overflows.
    assign rd_en       = start_go ||
                         ((state_q == PLAY) && !stop && !issue_done_q &&
                          ((credit_cnt < 2'd2) || pop));
    assign rd_addr     = start_go ? '0 : rd_ptr_q;
    assign rd_at_end   = (rd_addr == len_eff);

    // A load beat written on the start edge must be seen by the read of the same address.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
        if (rd_en) begin
            rd_data_q <= (wr_en && (wr_ptr_q == rd_addr)) ? s_axis_tdata : mem_q[rd_addr];
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        loop_d       = loop_q;
        issue_done_d = issue_done_q;
        wrap_d       = wrap_q;
        rd_valid_d   = rd_en;
        rd_last_d    = rd_en && rd_at_end;
        skid_v0_d    = skid_v0_q;
        skid_v1_d    = skid_v1_q;
        skid_l0_d    = skid_l0_q;
        skid_l1_d    = skid_l1_q;
        skid_d0_d    = skid_d0_q;
        skid_d1_d    = skid_d1_q;

        if (wr_en) begin
            wr_ptr_d = s_axis_tlast ? '0 : wr_ptr_q + 1'b1;
        end
        if (start_go) begin
            len_d        = play_len;
            loop_d       = loop_en;
            wrap_d       = '0;
            issue_done_d = 1'b0;
        end
        if (rd_en) begin
            rd_ptr_d = rd_at_end ? '0 : rd_addr + 1'b1;
            if (rd_at_end && !loop_eff) begin
                issue_done_d = 1'b1;
            end
        end
        if (last_accept && loop_q && (wrap_q != 16'hFFFF)) begin
            wrap_d = wrap_q + 16'd1;
        end

        // Empty entries hold zero so the head register can drive tdata directly.
        if (pop) begin
            skid_v0_d = skid_v1_q;
            skid_l0_d = skid_l1_q;
            skid_d0_d = skid_d1_q;
            skid_v1_d = 1'b0;
            skid_l1_d = 1'b0;
            skid_d1_d = '0;
        end
        if (rd_valid_q) begin
            if (!skid_v0_d) begin
                skid_v0_d = 1'b1;
                skid_l0_d = rd_last_q;
                skid_d0_d = rd_data_q;
            end else begin
                skid_v1_d = 1'b1;
                skid_l1_d = rd_last_q;
                skid_d1_d = rd_data_q;
            end
        end
        if (stop) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            skid_v0_d  = 1'b0;
            skid_v1_d  = 1'b0;
            skid_l0_d  = 1'b0;
            skid_l1_d  = 1'b0;
            skid_d0_d  = '0;
            skid_d1_d  = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            issue_done_q <= 1'b0;
            wrap_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            skid_v0_q    <= 1'b0;
            skid_v1_q    <= 1'b0;
            skid_l0_q    <= 1'b0;
            skid_l1_q    <= 1'b0;
            skid_d0_q    <= '0;
            skid_d1_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            loop_q       <= loop_d;
            issue_done_q <= issue_done_d;
            wrap_q       <= wrap_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            skid_v0_q    <= skid_v0_d;
            skid_v1_q    <= skid_v1_d;
            skid_l0_q    <= skid_l0_d;
            skid_l1_q    <= skid_l1_d;
            skid_d0_q    <= skid_d0_d;
            skid_d1_q    <= skid_d1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = PLAY;
            PLAY:    if (stop) state_d = IDLE;
                     else if (last_accept && !loop_q) state_d = DRAIN;
            DRAIN:   if (stop || (!skid_v0_q && !rd_valid_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DRAIN) && !skid_v0_q && !rd_valid_q && !stop;
        s_axis_tready = (state_q == IDLE);
    end

    assign m_axis_tvalid = skid_v0_q;
    assign m_axis_tdata  = skid_d0_q;
    assign m_axis_tlast  = skid_l0_q;
    assign wrap_count    = wrap_q;

endmodule

// File: tb/tb_dac_pattern_play.sv
// Directed bench for dac_pattern_play: one-shot, loop, backpressure, stop,
// collisions and mid-playback reset, checked with immediate assertions.
module tb_dac_pattern_play;

    localparam int DW = 128;
    localparam int AB = 10;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [AB-1:0] play_len;
    logic          loop_en, start, stop, busy, done;
    logic [15:0]   wrap_count;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

    int total = 0;
    int bad   = 0;

    dac_pattern_play #(.DWIDTH(DW), .ADDR_BITS(AB)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .play_len      (play_len),
        .loop_en       (loop_en),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .wrap_count    (wrap_count),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // Word k carries samples (k+1)*256 + s in lane s, so every word is distinct and nonzero.
    function automatic logic [DW-1:0] mkWord(input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int s = 0; s < 8; s++) begin
            w[s*16 +: 16] = 16'((k + 1) * 256 + s);
        end
        return w;
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AB-1:0] len, input logic lp);
        play_len = len;
        loop_en  = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic loadWords(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mkWord(base + i);
            s_axis_tlast  = (i == n - 1);
            checkOutput("load tready", DW'(s_axis_tready), DW'(1));
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
    endtask

    initial begin
        int          idx;
        logic        acc, prevStall;
        logic [DW-1:0] prevData;

        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        play_len      = '0;
        loop_en       = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
        checkOutput("reset busy",   DW'(busy),          DW'(0));
        checkOutput("reset done",   DW'(done),          DW'(0));
        checkOutput("reset tvalid", DW'(m_axis_tvalid), DW'(0));
        checkOutput("reset tdata",  m_axis_tdata,       '0);
        checkOutput("reset tlast",  DW'(m_axis_tlast),  DW'(0));
        checkOutput("reset wrap",   DW'(wrap_count),    DW'(0));
        checkOutput("reset sready", DW'(s_axis_tready), DW'(1));

        // One-shot of four words
        loadWords(4, 0);
        applyStimulus(10'd3, 1'b0);
        checkOutput("os busy T+1",   DW'(busy),          DW'(1));
        checkOutput("os tvalid T+1", DW'(m_axis_tvalid), DW'(0));
        checkOutput("os sready T+1", DW'(s_axis_tready), DW'(0));
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("os tvalid", DW'(m_axis_tvalid), DW'(1));
            checkOutput("os tdata",  m_axis_tdata,       mkWord(k));
            checkOutput("os tlast",  DW'(m_axis_tlast),  DW'(k == 3));
            checkOutput("os done",   DW'(done),          DW'(0));
            tick();
        end
        checkOutput("os done pulse",   DW'(done),          DW'(1));
        checkOutput("os tvalid after", DW'(m_axis_tvalid), DW'(0));
        checkOutput("os busy drain",   DW'(busy),          DW'(1));
        tick();
        checkOutput("os done end",  DW'(done),          DW'(0));
        checkOutput("os busy end",  DW'(busy),          DW'(0));
        checkOutput("os sready",    DW'(s_axis_tready), DW'(1));
        checkOutput("os wrap",      DW'(wrap_count),    DW'(0));

        // Continuous loop, 20 beats with no gaps
        applyStimulus(10'd3, 1'b1);
        tick();
        for (int k = 0; k < 20; k++) begin
            checkOutput("loop tdata", m_axis_tdata,      mkWord(k % 4));
            checkOutput("loop tlast", DW'(m_axis_tlast), DW'(k % 4 == 3));
            tick();
            if (k == 15) checkOutput("loop wrap16", DW'(wrap_count), DW'(4));
        end
        checkOutput("loop wrap20", DW'(wrap_count), DW'(5));

        // Start during PLAY is ignored
        checkOutput("loop beat20", m_axis_tdata, mkWord(0));
        play_len = 10'd0;
        loop_en  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart ignored", m_axis_tdata,     mkWord(1));
        checkOutput("restart busy",    DW'(busy),        DW'(1));
        checkOutput("restart wrap",    DW'(wrap_count),  DW'(5));

        // Stop mid-play
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop tvalid", DW'(m_axis_tvalid), DW'(0));
        checkOutput("stop tdata",  m_axis_tdata,       '0);
        checkOutput("stop busy",   DW'(busy),          DW'(0));
        checkOutput("stop done",   DW'(done),          DW'(0));
        checkOutput("stop sready", DW'(s_axis_tready), DW'(1));
        tick();
        checkOutput("stop done late", DW'(done), DW'(0));

        // Loop under random backpressure, replaying from W0
        applyStimulus(10'd3, 1'b1);
        tick();
        idx       = 0;
        prevStall = 1'b0;
        prevData  = '0;
        for (int c = 0; c < 48; c++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            checkOutput("bp tvalid", DW'(m_axis_tvalid), DW'(1));
            checkOutput("bp tdata",  m_axis_tdata,       mkWord(idx % 4));
            if (prevStall) checkOutput("bp stable", m_axis_tdata, prevData);
            acc       = m_axis_tvalid && m_axis_tready;
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevData  = m_axis_tdata;
            tick();
            if (acc) idx++;
        end
        m_axis_tready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Single-word loop
        applyStimulus(10'd0, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput("len0 tdata", m_axis_tdata,      mkWord(0));
            checkOutput("len0 tlast", DW'(m_axis_tlast), DW'(1));
            tick();
        end
        checkOutput("len0 wrap", DW'(wrap_count), DW'(5));

        // Reset mid-loop, then confirm RAM survived
        areset = 1'b1;
        tick();
        checkOutput("rst tvalid", DW'(m_axis_tvalid), DW'(0));
        checkOutput("rst tdata",  m_axis_tdata,       '0);
        checkOutput("rst tlast",  DW'(m_axis_tlast),  DW'(0));
        checkOutput("rst busy",   DW'(busy),          DW'(0));
        checkOutput("rst wrap",   DW'(wrap_count),    DW'(0));
        areset = 1'b0;
        tick();
        applyStimulus(10'd3, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("rst replay", m_axis_tdata, mkWord(k));
            tick();
        end
        checkOutput("rst replay done", DW'(done), DW'(1));
        tick();

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("ss busy",   DW'(busy),          DW'(0));
        checkOutput("ss sready", DW'(s_axis_tready), DW'(1));
        tick();
        checkOutput("ss tvalid", DW'(m_axis_tvalid), DW'(0));

        // Load beat into address 0 on the start edge is played
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mkWord(9);
        s_axis_tlast  = 1'b1;
        applyStimulus(10'd0, 1'b0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        checkOutput("raw busy", DW'(busy), DW'(1));
        tick();
        checkOutput("raw tdata", m_axis_tdata,      mkWord(9));
        checkOutput("raw tlast", DW'(m_axis_tlast), DW'(1));
        tick();
        checkOutput("raw done",   DW'(done),          DW'(1));
        checkOutput("raw tvalid", DW'(m_axis_tvalid), DW'(0));
        tick();
        checkOutput("raw idle", DW'(busy), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_pattern_play.md
# dac_pattern_play

Waveform playback buffer that sources the 128-bit, 8-samples-per-beat AXI4-Stream feeding the DAC 2:1 width/clock transfer stage. Software-supplied sample words are loaded into an internal block RAM over a slave stream. On command, the buffer is replayed in one-shot or continuous-loop mode on the DAC-side master stream. Runs entirely in the `aclk` domain, directly upstream of the x2 transfer into `aclk_div2`.

## Interface
- `DWIDTH` — 128 — stream word width; 8 × 16-bit samples, sample 0 in bits [15:0].
- `ADDR_BITS` — 10 — RAM address width; depth 2^ADDR_BITS words.
- `aclk` — in — 1 — single clock for all logic.
- `areset` — in — 1 — synchronous, active-high reset.
- `s_axis_tdata` — in — DWIDTH — load data.
- `s_axis_tvalid` — in — 1 — load beat valid.
- `s_axis_tready` — out — 1 — load beat accepted; high only in IDLE.
- `s_axis_tlast` — in — 1 — last load beat; write pointer returns to 0.
- `play_len` — in — ADDR_BITS — index of last word to play; sampled on start.
- `loop_en` — in — 1 — 1 = continuous loop, 0 = one-shot; sampled on start.
- `start` — in — 1 — single-cycle playback request.
- `stop` — in — 1 — single-cycle abort request.
- `busy` — out — 1 — state ≠ IDLE.
- `done` — out — 1 — one-cycle pulse on one-shot completion.
- `wrap_count` — out — 16 — completed loop passes; saturating.
- `m_axis_tdata` — out — DWIDTH — playback data; forced to 0 when `m_axis_tvalid` is low.
- `m_axis_tvalid` — out — 1 — playback beat valid.
- `m_axis_tready` — in — 1 — downstream accept.
- `m_axis_tlast` — out — 1 — marks the beat at index `play_len`.

## Operation
- States: IDLE, PLAY, DRAIN.
- **Reset:** state IDLE; write and read pointers 0. All outputs 0 except `s_axis_tready`, which is 1 in the first cycle after reset release. RAM contents are not cleared.
- **IDLE / load:**
  - Each `s_axis_tvalid & s_axis_tready` beat writes RAM[wr_ptr], then wr_ptr increments.
  - wr_ptr wraps from 2^ADDR_BITS−1 to 0.
  - `s_axis_tlast` on an accepted beat forces wr_ptr to 0.
- **IDLE → PLAY:** on `start & !stop`. Latches `play_len` and `loop_en`, sets rd_ptr=0, clears `wrap_count`.
- **Simultaneous `start` and `stop` in IDLE:** stop wins; remain IDLE.
- **A load beat accepted in the same cycle as `start`:** is written before the first read. Read-after-write on the same address returns the new data.
- **PLAY:**
  - Emits RAM[0..len] in order, then repeats from 0 if loop.
  - No dropped, duplicated, or reordered beats under any `m_axis_tready` pattern.
  - BRAM read latency is 1; a 2-entry output skid absorbs backpressure.
  - Sustains 1 beat/cycle with `m_axis_tready` held high.
- **Beat at index len accepted:**
  - Loop: rd_ptr restarts at 0; `wrap_count` increments, saturating at 0xFFFF.
  - One-shot: no further reads issued; go to DRAIN.
- **DRAIN:** wait until the skid is empty (the last beat is already accepted), pulse `done`, go to IDLE.
- **`stop` in PLAY or DRAIN:** flush the skid, deassert `m_axis_tvalid` next cycle, go to IDLE, no `done` pulse. In-flight beats are discarded.
- **`start` in PLAY or DRAIN:** ignored.
- **`play_len` = 0:** plays single word RAM[0] every beat (loop) or once (one-shot).

## Timing
- `start` sampled at edge T:
  - `busy`=1 from T+1.
  - `m_axis_tvalid`=1 with RAM[0] at T+2.
  - With `m_axis_tready`=1 throughout, beat k is presented at T+2+k.
- Loop wrap is seamless: RAM[0] follows RAM[len] on the next cycle.
- One-shot, last beat accepted at edge E:
  - `done`=1 for the cycle after E.
  - `busy`=0 the cycle after that.
  - `s_axis_tready`=1 the same cycle as `busy`=0.
- `stop` sampled at edge S: `m_axis_tvalid`=0 and `m_axis_tdata`=0 from S+1; `busy`=0 from S+1.
- `m_axis_tdata` and `m_axis_tvalid` are registered outputs; no combinational path from `m_axis_tready` to `m_axis_tvalid`.
- `areset` mid-playback: outputs as at reset on the next cycle; RAM is preserved.

## Test plan
- **One-shot:** load 4 words W0..W3 (W3 with tlast); `play_len`=3, `loop_en`=0, `start`. Expect tvalid at T+2; beats W0,W1,W2,W3; tlast only on W3; `done` 1 cycle; `wrap_count`=0.
- **Loop:** same load, `loop_en`=1, run 20 accepted beats. Expect W0..W3 repeating with no gaps; `wrap_count`=4 after the 16th beat's wrap is counted, 5 after the 20th.
- **Backpressure:** loop with random 50% `m_axis_tready`. Expect the accepted sequence to be exactly W0,W1,W2,W3,... with no loss or duplication; tdata stable while tvalid & !tready.
- **Stop:** assert `stop` mid-play. Expect tvalid=0 and tdata=0 the next cycle, no `done`, `s_axis_tready`=1; a subsequent `start` replays from W0.
- **Collisions:** `start`+`stop` in IDLE → remains IDLE; `start` during PLAY → no effect; `play_len`=0 loop → W0 every cycle.
- **Reset:** `areset` mid-loop → all outputs 0 next cycle. After release and a new `start`, RAM contents are intact.
